// File: rtl/rr_bus_arbiter.sv
// Round-robin arbiter for one shared bus: a one-hot grant is held until the owner
// is done, with a bus-hog timeout and a fixed all-low turnaround gap between owners.
module rr_bus_arbiter #(
  parameter int NUM_MASTERS    = 4,
  parameter int ID_W           = 2,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TURNAROUND     = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_MASTERS-1:0] Bus_RQ,
  input  logic                   Bus_Ready,
  output logic [NUM_MASTERS-1:0] Bus_GRANT,
  output logic                   Grant_Valid,
  output logic [ID_W-1:0]        Grant_Id,
  output logic                   Timeout_Pulse,
  output logic [ID_W-1:0]        Timeout_Id
);

  localparam int TCNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RCNT_W = (TURNAROUND > 1) ? $clog2(TURNAROUND) : 1;
  localparam logic [TCNT_W-1:0] TCNT_MAX = TCNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
  localparam logic [ID_W:0]     NM       = (ID_W+1)'(NUM_MASTERS);

  typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

  state_t                 state;
  logic [ID_W-1:0]        rr_ptr;
  logic [NUM_MASTERS-1:0] mask;
  logic [TCNT_W-1:0]      tcnt;
  logic [RCNT_W-1:0]      rcnt;

  logic [NUM_MASTERS-1:0]   eligible;
  logic [2*NUM_MASTERS-1:0] dbl;
  logic [NUM_MASTERS-1:0]   rot;
  logic [ID_W-1:0]          win_off;
  logic [ID_W:0]            win_sum;
  logic [ID_W:0]            ptr_sum;
  logic                     win_found;
  logic [ID_W-1:0]          win_id;
  logic [NUM_MASTERS-1:0]   win_onehot;
  logic [ID_W-1:0]          next_ptr;
  logic                     owner_done;
  logic                     hog;

  // Rotate the eligible vector so rr_ptr sits at bit 0, take the lowest set bit, rotate back.
  always_comb begin
    eligible  = Bus_RQ & ~mask;
    dbl       = {eligible, eligible} >> rr_ptr;
    rot       = dbl[NUM_MASTERS-1:0];
    win_found = 1'b0;
    win_off   = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (!win_found && rot[i]) begin
        win_found = 1'b1;
        win_off   = ID_W'(i);
      end
    end
    win_sum = {1'b0, rr_ptr} + {1'b0, win_off};
    if (win_sum >= NM) win_sum = win_sum - NM;
    win_id     = win_sum[ID_W-1:0];
    win_onehot = NUM_MASTERS'(1) << win_id;

    ptr_sum = {1'b0, Grant_Id} + {{ID_W{1'b0}}, 1'b1};
    if (ptr_sum >= NM) ptr_sum = '0;
    next_ptr = ptr_sum[ID_W-1:0];

    owner_done = ~Bus_RQ[Grant_Id] & ~Bus_Ready;
    hog        = (TIMEOUT_CYCLES != 0) && (tcnt == TCNT_MAX);
  end

  assign Grant_Valid = |Bus_GRANT;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      mask          <= '0;
      tcnt          <= '0;
      rcnt          <= '0;
      Bus_GRANT     <= '0;
      Grant_Id      <= '0;
      Timeout_Pulse <= 1'b0;
      Timeout_Id    <= '0;
    end else begin
      Timeout_Pulse <= 1'b0;
      Timeout_Id    <= '0;
      mask          <= mask & Bus_RQ;
      case (state)
        IDLE: begin
          if (win_found) begin
            Bus_GRANT <= win_onehot;
            Grant_Id  <= win_id;
            tcnt      <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          // A normal release wins over a coincident timeout: no pulse, no mask.
          if (owner_done || hog) begin
            Bus_GRANT <= '0;
            Grant_Id  <= '0;
            rr_ptr    <= next_ptr;
            tcnt      <= '0;
            rcnt      <= '0;
            state     <= RELEASE;
            if (!owner_done) begin
              Timeout_Pulse <= 1'b1;
              Timeout_Id    <= Grant_Id;
              mask          <= (mask | Bus_GRANT) & Bus_RQ;
            end
          end else begin
            tcnt <= tcnt + TCNT_W'(1);
          end
        end
        RELEASE: begin
          if (rcnt == RCNT_MAX) begin
            if (win_found) begin
              Bus_GRANT <= win_onehot;
              Grant_Id  <= win_id;
              tcnt      <= '0;
              state     <= GRANT;
            end else begin
              state <= IDLE;
            end
          end else begin
            rcnt <= rcnt + RCNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_bus_arbiter.sv
// Bench for rr_bus_arbiter: directed vector table, hand-written corner sequences,
// and random traffic compared every cycle against an ownership-level reference model.
module tb_rr_bus_arbiter;

  localparam int N  = 4;
  localparam int TO = 16;
  localparam int TA = 1;

  logic         clk;
  logic         reset;
  logic [N-1:0] Bus_RQ;
  logic         Bus_Ready;
  logic [N-1:0] Bus_GRANT;
  logic         Grant_Valid;
  logic [1:0]   Grant_Id;
  logic         Timeout_Pulse;
  logic [1:0]   Timeout_Id;

  rr_bus_arbiter #(
    .NUM_MASTERS(N), .ID_W(2), .TIMEOUT_CYCLES(TO), .TURNAROUND(TA)
  ) dut (
    .clk(clk), .reset(reset), .Bus_RQ(Bus_RQ), .Bus_Ready(Bus_Ready),
    .Bus_GRANT(Bus_GRANT), .Grant_Valid(Grant_Valid), .Grant_Id(Grant_Id),
    .Timeout_Pulse(Timeout_Pulse), .Timeout_Id(Timeout_Id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: who owns the bus, how long they have held it, remaining gap cycles.
  int           m_owner;
  int           m_held;
  int           m_gap;
  int           m_ptr;
  logic [N-1:0] m_mask;
  int           m_pulse;
  int           m_tid;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1; m_held = 0; m_gap = 0; m_ptr = 0;
    m_mask = '0; m_pulse = 0; m_tid = 0;
  endtask

  function automatic int pick(input logic [N-1:0] rq, input logic [N-1:0] msk, input int ptr);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (ptr + k) % N;
      if (rq[i] && !msk[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_step(input logic [N-1:0] rq, input logic rdy);
    int w;
    logic [N-1:0] set_m;
    w = pick(rq, m_mask, m_ptr);
    set_m = '0; m_pulse = 0; m_tid = 0;
    if (m_owner >= 0) begin
      m_held++;
      if (!rq[m_owner] && !rdy) begin
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = TA;
      end else if (m_held == TO) begin
        set_m[m_owner] = 1'b1; m_pulse = 1; m_tid = m_owner;
        m_ptr = (m_owner + 1) % N; m_owner = -1; m_gap = TA;
      end
    end else begin
      if (m_gap > 0) m_gap--;
      if (m_gap == 0 && w >= 0) begin
        m_owner = w; m_held = 0;
      end
    end
    m_mask = (m_mask | set_m) & rq;
  endtask

  task automatic check_model();
    int eg;
    eg = (m_owner >= 0) ? (1 << m_owner) : 0;
    chk("grant", int'(Bus_GRANT), eg);
    chk("valid", int'(Grant_Valid), (m_owner >= 0) ? 1 : 0);
    chk("grant_id", int'(Grant_Id), (m_owner >= 0) ? m_owner : 0);
    chk("to_pulse", int'(Timeout_Pulse), m_pulse);
    chk("to_id", int'(Timeout_Id), m_tid);
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are read 1 unit after the next.
  task automatic cycle(input logic [N-1:0] rq, input logic rdy);
    Bus_RQ = rq; Bus_Ready = rdy;
    @(posedge clk);
    if (reset) model_step(rq, rdy);
    #1;
    check_model();
  endtask

  task automatic check_all_zero(input string nm);
    chk({nm, "_grant"}, int'(Bus_GRANT), 0);
    chk({nm, "_valid"}, int'(Grant_Valid), 0);
    chk({nm, "_id"}, int'(Grant_Id), 0);
    chk({nm, "_pulse"}, int'(Timeout_Pulse), 0);
    chk({nm, "_tid"}, int'(Timeout_Id), 0);
  endtask

  task automatic do_reset();
    Bus_RQ = '0; Bus_Ready = 1'b0;
    reset = 1'b0;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  typedef struct packed {
    logic [N-1:0] rq;
    logic         rdy;
    logic [N-1:0] grant;
    logic [1:0]   id;
  } vec_t;

  vec_t vecs[21];

  initial begin
    int hi;
    int pulses;
    logic [N-1:0] rrq;

    vecs[0]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    vecs[1]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[2]  = '{4'b0100, 1'b0, 4'b0100, 2'd2};
    vecs[3]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    vecs[4]  = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    vecs[5]  = '{4'b1111, 1'b0, 4'b1000, 2'd3};
    vecs[6]  = '{4'b1111, 1'b1, 4'b1000, 2'd3};
    vecs[7]  = '{4'b0111, 1'b1, 4'b1000, 2'd3};
    vecs[8]  = '{4'b0111, 1'b1, 4'b1000, 2'd3};
    vecs[9]  = '{4'b0111, 1'b0, 4'b0000, 2'd0};
    vecs[10] = '{4'b1111, 1'b0, 4'b0001, 2'd0};
    vecs[11] = '{4'b1111, 1'b0, 4'b0001, 2'd0};
    vecs[12] = '{4'b1110, 1'b0, 4'b0000, 2'd0};
    vecs[13] = '{4'b1111, 1'b0, 4'b0010, 2'd1};
    vecs[14] = '{4'b1101, 1'b0, 4'b0000, 2'd0};
    vecs[15] = '{4'b1101, 1'b0, 4'b0100, 2'd2};
    vecs[16] = '{4'b1001, 1'b0, 4'b0000, 2'd0};
    vecs[17] = '{4'b1001, 1'b0, 4'b1000, 2'd3};
    vecs[18] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    vecs[19] = '{4'b0000, 1'b0, 4'b0000, 2'd0};
    vecs[20] = '{4'b0000, 1'b0, 4'b0000, 2'd0};

    do_reset();

    for (int v = 0; v < 21; v++) begin
      cycle(vecs[v].rq, vecs[v].rdy);
      chk($sformatf("vec%0d_grant", v), int'(Bus_GRANT), int'(vecs[v].grant));
      chk($sformatf("vec%0d_id", v), int'(Grant_Id), int'(vecs[v].id));
    end

    // Bus hog: master 1 holds RQ for 25 cycles.
    hi = 0; pulses = 0;
    for (int c = 0; c < 25; c++) begin
      cycle(4'b0010, 1'b0);
      if (Bus_GRANT[1]) hi++;
      if (Timeout_Pulse) begin
        pulses++;
        chk("to_seq_id", int'(Timeout_Id), 1);
      end
    end
    chk("to_hold_cycles", hi, TO);
    chk("to_pulse_count", pulses, 1);
    cycle(4'b0000, 1'b0);
    chk("to_dropped", int'(Bus_GRANT), 0);
    cycle(4'b0010, 1'b0);
    chk("to_regrant", int'(Bus_GRANT), 2);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // Collision with rr_ptr=0: master 0 first, master 3 after one low cycle.
    do_reset();
    cycle(4'b1001, 1'b0);
    chk("coll_first", int'(Bus_GRANT), 1);
    cycle(4'b1001, 1'b0);
    chk("coll_hold", int'(Bus_GRANT), 1);
    cycle(4'b1000, 1'b0);
    chk("coll_gap", int'(Bus_GRANT), 0);
    cycle(4'b1000, 1'b0);
    chk("coll_second", int'(Bus_GRANT), 8);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // Asynchronous reset in the middle of a grant.
    do_reset();
    cycle(4'b0010, 1'b0);
    chk("arst_pre", int'(Bus_GRANT), 2);
    #3 reset = 1'b0;
    #1 check_all_zero("arst_mid");
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    cycle(4'b0001, 1'b0);
    chk("arst_after", int'(Bus_GRANT), 1);
    cycle(4'b0000, 1'b0);
    cycle(4'b0000, 1'b0);

    // Random traffic with sticky requests so timeouts and Ready holds both occur.
    rrq = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(7) == 0) rrq[i] = ~rrq[i];
      cycle(rrq, ($urandom_range(2) == 0));
      chk("onehot", ($countones(Bus_GRANT) <= 1) ? 1 : 0, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
